wave_capture: RTL

WAVE_CAPTURE -- requirements
Module: wave_capture

---
 rtl/wave_capture.sv | 106 ++++++++++
 1 files changed

// File: rtl/wave_capture.sv
// wave_capture: triggered oscilloscope-style capture of an audio stream into
// a double-buffered sample RAM.  A negative-to-non-negative zero crossing arms
// a 256-entry capture into the bank the display is not reading; once the bank
// is full the block waits for the display to go idle, then swaps banks.
module wave_capture #(
    parameter int DECIMATE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_sample_ready,
    input  logic signed [15:0] new_sample_in,
    input  logic               wave_display_idle,
    output logic        [8:0]  write_address,
    output logic               write_enable,
    output logic        [7:0]  write_sample,
    output logic               read_index
);

    typedef enum logic [1:0] {
        ARMED,
        ACTIVE,
        WAIT
    } state_t;

    // Decimation count value at which the current sample is stored.
    localparam logic [7:0] DEC_LAST = 8'(DECIMATE - 1);

    state_t             state;
    logic signed [15:0] prev;
    logic        [7:0]  index;
    logic        [7:0]  dec_count;
    logic               trigger;
    logic               dec_due;

    // Signed sample to offset-binary byte: keep the top 8 bits, flip the sign.
    function automatic logic [7:0] to_offset_binary(input logic signed [15:0] s);
        return {~s[15], s[14:8]};
    endfunction

    // Zero crossing from a negative previous sample to a non-negative new one.
    assign trigger = new_sample_ready && (prev < 16'sd0) && (new_sample_in >= 16'sd0);
    assign dec_due = (dec_count == DEC_LAST);

    assign write_address = {~read_index, index};
    assign write_sample  = to_offset_binary(new_sample_in);

    // Write strobe is combinational so the RAM sees the sample in its strobe cycle.
    always_comb begin
        write_enable = 1'b0;
        if (!reset && new_sample_ready) begin
            case (state)
                ARMED:   write_enable = trigger;
                ACTIVE:  write_enable = dec_due;
                default: write_enable = 1'b0;
            endcase
        end
    end

    // Capture state machine, sample history, write index and bank select.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARMED;
            prev       <= 16'sd0;
            index      <= 8'd0;
            dec_count  <= 8'd0;
            read_index <= 1'b0;
        end else begin
            if (new_sample_ready) begin
                prev <= new_sample_in;
            end
            case (state)
                ARMED: begin
                    // Trigger sample lands at index 0 this cycle; continue at 1.
                    if (trigger) begin
                        index     <= 8'd1;
                        dec_count <= 8'd0;
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (new_sample_ready) begin
                        if (dec_due) begin
                            dec_count <= 8'd0;
                            // Index wraps to 0 after entry 255, ready for the next capture.
                            index     <= index + 8'd1;
                            if (index == 8'd255) begin
                                state <= WAIT;
                            end
                        end else begin
                            dec_count <= dec_count + 8'd1;
                        end
                    end
                end
                WAIT: begin
                    // Swap banks only while the display is not drawing.
                    if (wave_display_idle) begin
                        read_index <= ~read_index;
                        state      <= ARMED;
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end

endmodule
